// File: rtl/munch_frame_sequencer.sv
// Purpose : frame-synchronous run/stop/pause/step sequencer and pixel colour stage for munching squares.
// Latency : R/G/B registered one cycle after hpos/vpos/display_on; frame/state update the cycle after a vsync fall.
// Backpressure: one-entry command slot; cmd_ready low from acceptance until the next frame boundary.
//
// Ports: clk/rst_n (sync, active-low); vsync/display_on/hpos/vpos from hvsync_generator;
//        cmd_valid/cmd_ready/cmd_op/cmd_arg command handshake; R/G/B pixel colour; frame/state status.
// Build option: MUNCH_SEQ_COLOR_EN selects frame-derived colour; undefined gives monochrome (2'b11 when lit).
module munch_frame_sequencer #(
    parameter int DIV_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             display_on,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_arg,
    output logic [1:0]       R,
    output logic [1:0]       G,
    output logic [1:0]       B,
    output logic [7:0]       frame,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_STEP  = 2'b11
    } state_t;

    localparam logic [1:0]       OP_STOP  = 2'd0;
    localparam logic [1:0]       OP_RUN   = 2'd1;
    localparam logic [1:0]       OP_PSTEP = 2'd2;
    localparam logic [1:0]       OP_DIV   = 2'd3;
    localparam logic [DIV_W-1:0] CNT_ONE  = 1;

    state_t           st_q, st_d;
    logic [7:0]       frame_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             vsync_q;
    logic             fb;
    logic             pend_v;
    logic [1:0]       pend_op;
    logic [DIV_W-1:0] pend_arg;
    logic             accept;
    logic             lit;
    logic [1:0]       r_d, g_d, b_d;

    // Only the low 8 bits of position feed the XOR pattern.
    logic unused_pos;
    assign unused_pos = &{1'b0, hpos[9:8], vpos[9:8]};

    assign fb        = vsync_q & ~vsync;
    assign cmd_ready = ~pend_v;
    assign accept    = cmd_valid & ~pend_v;
    assign state     = st_q;

    function automatic logic [1:0] nz(input logic [1:0] c);
        return (c == 2'b00) ? 2'b01 : c;
    endfunction

    // Next frame/divider/state: advance on the pre-boundary state first, then let a
    // pending command (accepted before this boundary) override.
    always_comb begin
        st_d      = st_q;
        frame_d   = frame;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        if (fb) begin
            case (st_q)
                ST_STOP: begin
                    frame_d   = 8'd0;
                    div_cnt_d = '0;
                end
                ST_RUN: begin
                    if (div_cnt_q == div_q) begin
                        div_cnt_d = '0;
                        frame_d   = frame + 8'd1;
                    end else begin
                        div_cnt_d = div_cnt_q + CNT_ONE;
                    end
                end
                ST_PAUSE: ;
                ST_STEP: begin
                    frame_d   = frame + 8'd1;
                    div_cnt_d = '0;
                    st_d      = ST_PAUSE;
                end
                default: ;
            endcase
            if (pend_v) begin
                case (pend_op)
                    OP_STOP: begin
                        st_d      = ST_STOP;
                        frame_d   = 8'd0;
                        div_cnt_d = '0;
                    end
                    OP_RUN:   st_d = ST_RUN;
                    // A second PAUSE/STEP while paused (or mid-step) requests one more step.
                    OP_PSTEP: st_d = (st_q == ST_STOP || st_q == ST_RUN) ? ST_PAUSE : ST_STEP;
                    OP_DIV: begin
                        div_d     = pend_arg;
                        div_cnt_d = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pixel colour from the registered frame.
    always_comb begin
        lit = display_on & ((hpos[7:0] ^ vpos[7:0]) < frame);
        r_d = 2'b00;
        g_d = 2'b00;
        b_d = 2'b00;
        if (lit) begin
`ifdef MUNCH_SEQ_COLOR_EN
            r_d = nz(frame[7:6]);
            g_d = nz(frame[5:4]);
            b_d = nz(frame[3:2]);
`else
            r_d = 2'b11;
            g_d = 2'b11;
            b_d = 2'b11;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q   <= 1'b1;
            st_q      <= ST_STOP;
            frame     <= 8'd0;
            div_q     <= '0;
            div_cnt_q <= '0;
            pend_v    <= 1'b0;
            pend_op   <= 2'b00;
            pend_arg  <= '0;
            R         <= 2'b00;
            G         <= 2'b00;
            B         <= 2'b00;
        end else begin
            vsync_q   <= vsync;
            st_q      <= st_d;
            frame     <= frame_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            // accept implies the slot was empty, so a command landing on a boundary
            // cycle stays pending for the next boundary.
            if (accept) begin
                pend_v   <= 1'b1;
                pend_op  <= cmd_op;
                pend_arg <= cmd_arg;
            end else if (fb) begin
                pend_v   <= 1'b0;
            end
            R <= r_d;
            G <= g_d;
            B <= b_d;
        end
    end

endmodule

// File: tb/tb_munch_frame_sequencer.sv
// Purpose : directed stimulus with a scoreboard queue and an independent negedge monitor.
// Latency : expectations carry the cycle they are due in; the monitor compares at that negedge.
// Backpressure: command sends wait on cmd_ready with a bounded cycle budget.
module tb_munch_frame_sequencer;

    localparam int K_FRAME = 0;
    localparam int K_STATE = 1;
    localparam int K_RGB   = 2;
    localparam int K_RDY   = 3;

`ifdef MUNCH_SEQ_COLOR_EN
    localparam logic [5:0] RGB_F02 = 6'b01_01_01;
    localparam logic [5:0] RGB_F80 = 6'b10_01_01;
`else
    localparam logic [5:0] RGB_F02 = 6'b11_11_11;
    localparam logic [5:0] RGB_F80 = 6'b11_11_11;
`endif

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       display_on = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [5:0] cmd_arg = '0;
    logic [1:0] R, G, B;
    logic [7:0] frame;
    logic [1:0] state;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    munch_frame_sequencer #(.DIV_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .R(R), .G(G), .B(B),
        .frame(frame), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due by this cycle and compares against the live outputs.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_FRAME: act = frame;
                K_STATE: act = {6'b0, state};
                K_RGB:   act = {2'b0, R, G, B};
                default: act = {7'b0, cmd_ready};
            endcase
            n_total++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s @cyc %0d: got 0x%02h expected 0x%02h", e.name, cyc, act, e.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input int kind, input logic [7:0] exp);
        exp_t e;
        e.due  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [5:0] arg);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL cmd_handshake_timeout: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, n);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // One frame boundary; frame/state are checked in the cycle after the strobe.
    task automatic edge_chk(input string name, input logic [7:0] f_exp, input logic [1:0] s_exp);
        vsync = 1'b0;
        tick();
        expect_now({name, "_frame"}, K_FRAME, f_exp);
        expect_now({name, "_state"}, K_STATE, {6'b0, s_exp});
        vsync = 1'b1;
        tick();
    endtask

    task automatic edge_only();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] div_tab [6];
        div_tab = '{8'd4, 8'd4, 8'd5, 8'd5, 8'd5, 8'd6};

        // Reset
        repeat (3) tick();
        expect_now("rst_frame", K_FRAME, 8'd0);
        expect_now("rst_state", K_STATE, 8'd0);
        expect_now("rst_rgb",   K_RGB,   8'd0);
        expect_now("rst_rdy",   K_RDY,   8'd1);
        rst_n = 1'b1;
        tick();
        expect_now("post_rst_rdy", K_RDY, 8'd1);

        // RUN with div=0, frame 0 draws nothing
        display_on = 1'b1;
        send_cmd(2'd1, 6'd0);
        expect_now("run_pend_rdy", K_RDY, 8'd0);
        edge_chk("run_fb0", 8'd0, 2'b01);
        expect_now("run_fb0_rdy", K_RDY, 8'd1);
        expect_now("frame0_rgb", K_RGB, 8'd0);
        edge_chk("run_fb1", 8'd1, 2'b01);
        edge_chk("run_fb2", 8'd2, 2'b01);

        // Pixel compare boundary at frame 2
        hpos = 10'd1; vpos = 10'd0;
        tick();
        expect_now("pix_f2_lit", K_RGB, {2'b0, RGB_F02});
        hpos = 10'd2;
        tick();
        expect_now("pix_f2_equal_unlit", K_RGB, 8'd0);
        hpos = 10'd0;

        // Handshake: RUN pending, SET_DIV held until the slot frees
        send_cmd(2'd1, 6'd0);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_arg = 6'd2;
        expect_now("hs_rdy_low0", K_RDY, 8'd0);
        tick();
        expect_now("hs_rdy_low1", K_RDY, 8'd0);
        vsync = 1'b0;
        tick();
        expect_now("hs_fb_frame", K_FRAME, 8'd3);
        expect_now("hs_fb_rdy",   K_RDY,   8'd1);
        vsync = 1'b1;
        tick();
        cmd_valid = 1'b0;
        expect_now("hs_setdiv_taken", K_RDY, 8'd0);
        edge_chk("hs_setdiv_apply", 8'd4, 2'b01);

        // Divider = 2: advance every third boundary
        for (int i = 0; i < 6; i++) edge_chk($sformatf("div2_fb%0d", i), div_tab[i], 2'b01);

        // Back to div 0 and run through the 255 -> 0 wrap
        send_cmd(2'd3, 6'd0);
        edge_chk("div0_apply", 8'd6, 2'b01);
        for (int i = 0; i < 248; i++) edge_only();
        edge_chk("wrap_255", 8'd255, 2'b01);
        edge_chk("wrap_0", 8'd0, 2'b01);
        for (int i = 0; i < 127; i++) edge_only();
        edge_chk("frame_80", 8'h80, 2'b01);

        // Pixel colour at frame 0x80
        hpos = 10'd5; vpos = 10'd3; display_on = 1'b1;
        tick();
        expect_now("pix_f80_lit", K_RGB, {2'b0, RGB_F80});
        display_on = 1'b0;
        tick();
        expect_now("pix_f80_blank", K_RGB, 8'd0);

        // Pause / step
        send_cmd(2'd2, 6'd0);
        edge_chk("pause_apply", 8'h81, 2'b10);
        edge_chk("pause_hold", 8'h81, 2'b10);
        send_cmd(2'd2, 6'd0);
        edge_chk("step_apply", 8'h81, 2'b11);
        edge_chk("step_done", 8'h82, 2'b10);
        edge_chk("step_once", 8'h82, 2'b10);

        // Command accepted on the boundary cycle waits for the next one
        vsync = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1;
        tick();
        cmd_valid = 1'b0;
        expect_now("sim_state_held", K_STATE, 8'd2);
        expect_now("sim_rdy_low",    K_RDY,   8'd0);
        vsync = 1'b1;
        tick();
        edge_chk("sim_apply", 8'h82, 2'b01);
        edge_chk("sim_run", 8'h83, 2'b01);

        // STOP clears frame, overriding the advance
        send_cmd(2'd0, 6'd0);
        edge_chk("stop_apply", 8'd0, 2'b00);
        edge_chk("stop_hold", 8'd0, 2'b00);

        // Reset discards a pending command
        send_cmd(2'd1, 6'd0);
        expect_now("rst_mid_pend", K_RDY, 8'd0);
        rst_n = 1'b0;
        tick();
        expect_now("rst_mid_rdy", K_RDY, 8'd1);
        rst_n = 1'b1;
        tick();
        expect_now("rst_exit_rdy", K_RDY, 8'd1);
        edge_chk("rst_discard", 8'd0, 2'b00);

        // vsync held low strobes only once
        send_cmd(2'd1, 6'd0);
        edge_chk("held_run", 8'd0, 2'b01);
        vsync = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        tick();
        expect_now("held_low_once", K_FRAME, 8'd1);
        edge_chk("held_next", 8'd2, 2'b01);

        repeat (3) tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            $display("FAIL %s: never compared, expected 0x%02h", e.name, e.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
